// File: rtl/cpu_ctrl_pkg.sv
// rtl/cpu_ctrl_pkg.sv - shared types and encodings for the multicycle control sequencer
package cpu_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
    } state_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0, ALU_SUB = 4'd1, ALU_SLL = 4'd2, ALU_SLT = 4'd3,
        ALU_SLTU = 4'd4, ALU_XOR = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
        ALU_OR   = 4'd8, ALU_AND = 4'd9
    } alu_op_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0, IMM_S = 3'd1, IMM_SB = 3'd2, IMM_UJ = 3'd3, IMM_U = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        MTR_MEM = 2'd0, MTR_ALU = 2'd1, MTR_PC = 2'd2, MTR_IMM = 2'd3
    } mem_to_reg_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef struct packed {
        alu_op_e     alu_control;
        imm_sel_e    imm_sel;
        mem_to_reg_e mem_to_reg;
        logic        alu_src_b;
        logic        jump;
        logic        branch;
        logic        inverse_branch;
        logic        pc_offset;
    } ctrl_bundle_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_from_funct(input logic [2:0] funct3, input logic alt);
        alu_op_e op;
        case (funct3)
            3'd0:    op = alt ? ALU_SUB : ALU_ADD;
            3'd1:    op = ALU_SLL;
            3'd2:    op = ALU_SLT;
            3'd3:    op = ALU_SLTU;
            3'd4:    op = ALU_XOR;
            3'd5:    op = alt ? ALU_SRA : ALU_SRL;
            3'd6:    op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - control-signal bundle between sequencer and datapath
interface multicycle_ctrl_if;
    logic [3:0] ALU_Control;
    logic [2:0] ImmSel;
    logic [1:0] MemtoReg;
    logic       ALUSrc_B;
    logic       Jump;
    logic       Branch;
    logic       InverseBranch;
    logic       PCOffset;
    logic       RegWrite;

    modport control_unit (
        output ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch,
               InverseBranch, PCOffset, RegWrite
    );

    modport datapath (
        input  ALU_Control, ImmSel, MemtoReg, ALUSrc_B, Jump, Branch,
               InverseBranch, PCOffset, RegWrite
    );
endinterface

// File: rtl/multicycle_decode.sv
// rtl/multicycle_decode.sv - combinational instruction decode into the control bundle
module multicycle_decode
    import cpu_ctrl_pkg::*;
(
    input  logic [31:0]  instr,
    output ctrl_bundle_t bundle,
    output logic         is_load,
    output logic         is_store,
    output logic         is_branch,
    output logic         writes_rd,
    output logic         illegal
);
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic       alt;
    logic       wr;
    logic       unused_bits;

    assign opcode      = instr[6:0];
    assign rd          = instr[11:7];
    assign funct3      = instr[14:12];
    assign alt         = instr[30];
    assign unused_bits = ^{instr[31], instr[29:15]};

    always_comb begin
        bundle    = '0;
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_branch = 1'b0;
        wr        = 1'b0;
        illegal   = 1'b0;
        case (opcode)
            OP_R: begin
                bundle.alu_control = alu_from_funct(funct3, alt);
                bundle.mem_to_reg  = MTR_ALU;
                wr                 = 1'b1;
            end
            OP_IMM: begin
                // only the shift-right immediate carries the funct7 alternate bit
                bundle.alu_control = alu_from_funct(funct3, (funct3 == 3'd5) && alt);
                bundle.alu_src_b   = 1'b1;
                bundle.imm_sel     = IMM_I;
                bundle.mem_to_reg  = MTR_ALU;
                wr                 = 1'b1;
            end
            OP_LOAD: begin
                bundle.alu_src_b  = 1'b1;
                bundle.imm_sel    = IMM_I;
                bundle.mem_to_reg = MTR_MEM;
                is_load           = 1'b1;
                wr                = 1'b1;
            end
            OP_STORE: begin
                bundle.alu_src_b = 1'b1;
                bundle.imm_sel   = IMM_S;
                is_store         = 1'b1;
            end
            OP_BRANCH: begin
                if (funct3[2:1] == 2'b00) begin
                    bundle.branch         = 1'b1;
                    bundle.inverse_branch = funct3[0];
                    bundle.imm_sel        = IMM_SB;
                    bundle.alu_control    = ALU_SUB;
                    is_branch             = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_JAL: begin
                bundle.jump       = 1'b1;
                bundle.imm_sel    = IMM_UJ;
                bundle.mem_to_reg = MTR_PC;
                wr                = 1'b1;
            end
            OP_JALR: begin
                bundle.jump       = 1'b1;
                bundle.pc_offset  = 1'b1;
                bundle.alu_src_b  = 1'b1;
                bundle.imm_sel    = IMM_I;
                bundle.mem_to_reg = MTR_PC;
                wr                = 1'b1;
            end
            OP_LUI: begin
                bundle.imm_sel    = IMM_U;
                bundle.mem_to_reg = MTR_IMM;
                wr                = 1'b1;
            end
            OP_AUIPC: begin
                bundle.imm_sel    = IMM_U;
                bundle.mem_to_reg = MTR_PC;
                wr                = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        writes_rd = wr && (rd != 5'd0);
    end
endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle control sequencer; MULTICYCLE_ILLEGAL_TRAP_EN traps illegal opcodes
module multicycle_ctrl
    import cpu_ctrl_pkg::*;
#(
    parameter int unsigned IMEM_TIMEOUT = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [31:0]                  instr,
    output logic                         imem_req,
    input  logic                         imem_ready,
    output logic                         ir_we,
    output logic                         dmem_req,
    output logic                         dmem_we,
    input  logic                         dmem_ready,
    output logic                         pc_we,
    multicycle_ctrl_if.control_unit      ctrl,
    output logic                         fault
);
    localparam int unsigned      CNT_W  = $clog2(IMEM_TIMEOUT + 2);
    localparam logic [CNT_W-1:0] TO_LIM = CNT_W'(IMEM_TIMEOUT);

    state_e           state;
    ctrl_bundle_t     ctrl_q;
    logic             is_load_q, is_store_q, is_branch_q, writes_rd_q;
    logic             pc_we_q, reg_write;
    logic [CNT_W-1:0] wait_cnt, wait_nxt;

    ctrl_bundle_t dec_bundle;
    logic         dec_load, dec_store, dec_branch, dec_writes_rd, dec_illegal;

    multicycle_decode u_decode (
        .instr     (instr),
        .bundle    (dec_bundle),
        .is_load   (dec_load),
        .is_store  (dec_store),
        .is_branch (dec_branch),
        .writes_rd (dec_writes_rd),
        .illegal   (dec_illegal)
    );

    // the only ready-dependent outputs: request flops are high only in FETCH / MEM
    assign ir_we    = imem_req & imem_ready;
    assign pc_we    = pc_we_q | (dmem_req & dmem_we & dmem_ready);
    assign wait_nxt = wait_cnt + 1'b1;

    assign ctrl.ALU_Control   = ctrl_q.alu_control;
    assign ctrl.ImmSel        = ctrl_q.imm_sel;
    assign ctrl.MemtoReg      = ctrl_q.mem_to_reg;
    assign ctrl.ALUSrc_B      = ctrl_q.alu_src_b;
    assign ctrl.Jump          = ctrl_q.jump;
    assign ctrl.Branch        = ctrl_q.branch;
    assign ctrl.InverseBranch = ctrl_q.inverse_branch;
    assign ctrl.PCOffset      = ctrl_q.pc_offset;
    assign ctrl.RegWrite      = reg_write;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            ctrl_q      <= '0;
            is_load_q   <= 1'b0;
            is_store_q  <= 1'b0;
            is_branch_q <= 1'b0;
            writes_rd_q <= 1'b0;
            pc_we_q     <= 1'b0;
            reg_write   <= 1'b0;
            imem_req    <= 1'b0;
            dmem_req    <= 1'b0;
            dmem_we     <= 1'b0;
            fault       <= 1'b0;
            wait_cnt    <= '0;
        end else begin
            pc_we_q   <= 1'b0;
            reg_write <= 1'b0;
            case (state)
                S_IDLE: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                end
                S_FETCH: begin
                    if (imem_ready) begin
                        imem_req <= 1'b0;
                        state    <= S_DECODE;
                    end else if (IMEM_TIMEOUT != 0) begin
                        if (wait_cnt != TO_LIM) wait_cnt <= wait_nxt;
                        if (wait_nxt == TO_LIM) begin
                            imem_req <= 1'b0;
                            fault    <= 1'b1;
                            state    <= S_HALT;
                        end
                    end
                end
                S_DECODE: begin
                    if (dec_illegal) begin
                        ctrl_q      <= '0;
                        is_load_q   <= 1'b0;
                        is_store_q  <= 1'b0;
                        is_branch_q <= 1'b0;
                        writes_rd_q <= 1'b0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
                        fault       <= 1'b1;
                        state       <= S_HALT;
`else
                        state       <= S_EXEC;
`endif
                    end else begin
                        ctrl_q      <= dec_bundle;
                        is_load_q   <= dec_load;
                        is_store_q  <= dec_store;
                        is_branch_q <= dec_branch;
                        writes_rd_q <= dec_writes_rd;
                        pc_we_q     <= dec_branch;
                        state       <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (is_load_q || is_store_q) begin
                        state    <= S_MEM;
                        dmem_req <= 1'b1;
                        dmem_we  <= is_store_q;
                    end else if (is_branch_q) begin
                        state    <= S_FETCH;
                        imem_req <= 1'b1;
                        wait_cnt <= '0;
                    end else begin
                        state     <= S_WB;
                        pc_we_q   <= 1'b1;
                        reg_write <= writes_rd_q;
                    end
                end
                S_MEM: begin
                    if (dmem_ready) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        if (is_store_q) begin
                            state    <= S_FETCH;
                            imem_req <= 1'b1;
                            wait_cnt <= '0;
                        end else begin
                            state     <= S_WB;
                            pc_we_q   <= 1'b1;
                            reg_write <= writes_rd_q;
                        end
                    end
                end
                S_WB: begin
                    state    <= S_FETCH;
                    imem_req <= 1'b1;
                    wait_cnt <= '0;
                end
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl
module tb_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr = '0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, ir_we, dmem_req, dmem_we, pc_we, fault;
    int          n_tests = 0;
    int          n_fail  = 0;

    multicycle_ctrl_if cif ();

    multicycle_ctrl #(.IMEM_TIMEOUT(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .instr      (instr),
        .imem_req   (imem_req),
        .imem_ready (imem_ready),
        .ir_we      (ir_we),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .dmem_ready (dmem_ready),
        .pc_we      (pc_we),
        .ctrl       (cif.control_unit),
        .fault      (fault)
    );

    always #5 clk = ~clk;

    // strobe vector: {imem_req, ir_we, dmem_req, dmem_we, pc_we, RegWrite, fault}
    function automatic logic [6:0] strobes();
        return {imem_req, ir_we, dmem_req, dmem_we, pc_we, cif.RegWrite, fault};
    endfunction

    // ctrl vector: {ALU_Control[3:0], ImmSel[2:0], MemtoReg[1:0], ALUSrc_B, Jump, Branch, InverseBranch, PCOffset}
    function automatic logic [14:0] ctrl_vec();
        return {cif.ALU_Control, cif.ImmSel, cif.MemtoReg, cif.ALUSrc_B,
                cif.Jump, cif.Branch, cif.InverseBranch, cif.PCOffset};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input string tag, input logic im_r, input logic dm_r, input logic [6:0] exp);
        @(posedge clk);
        #2;
        imem_ready = im_r;
        dmem_ready = dm_r;
        #1;
        check(tag, 32'(strobes()), 32'(exp));
    endtask

    task automatic pulse_reset(input string tag);
        @(posedge clk);
        #2;
        rst_n      = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check(tag, {10'd0, strobes(), ctrl_vec()}, 32'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        #11;
        check("reset_outputs", {10'd0, strobes(), ctrl_vec()}, 32'd0);
        check("reset_wait_cnt", 32'(dut.wait_cnt), 32'd0);
        #1 rst_n = 1'b1;
        #1 check("idle", 32'(strobes()), 32'd0);

        // ADD x3,x1,x2
        instr = 32'h002081B3;
        tick("add_fetch",  1'b1, 1'b0, 7'b1100000);
        tick("add_decode", 1'b0, 1'b0, 7'b0000000);
        tick("add_exec",   1'b0, 1'b0, 7'b0000000);
        check("add_ctrl", 32'(ctrl_vec()), 32'({4'd0, 3'd0, 2'd1, 5'b00000}));
        tick("add_wb",     1'b0, 1'b0, 7'b0000110);

        // LW x5,8(x1) with stray readies in DECODE and three dmem wait cycles
        instr = 32'h0080A283;
        tick("lw_fetch",   1'b1, 1'b0, 7'b1100000);
        tick("lw_decode",  1'b1, 1'b1, 7'b0000000);
        tick("lw_exec",    1'b0, 1'b0, 7'b0000000);
        check("lw_ctrl", 32'(ctrl_vec()), 32'({4'd0, 3'd0, 2'd0, 5'b10000}));
        tick("lw_mem_w1",  1'b0, 1'b0, 7'b0010000);
        tick("lw_mem_w2",  1'b0, 1'b0, 7'b0010000);
        tick("lw_mem_w3",  1'b0, 1'b0, 7'b0010000);
        tick("lw_mem_rdy", 1'b0, 1'b1, 7'b0010000);
        tick("lw_wb",      1'b0, 1'b0, 7'b0000110);

        // SW x2,4(x1)
        instr = 32'h0020A223;
        tick("sw_fetch",  1'b1, 1'b0, 7'b1100000);
        tick("sw_decode", 1'b0, 1'b0, 7'b0000000);
        tick("sw_exec",   1'b0, 1'b0, 7'b0000000);
        check("sw_immsel", 32'(cif.ImmSel), 32'd1);
        tick("sw_mem",    1'b0, 1'b1, 7'b0011100);

        // BNE x1,x2,+8 after two fetch wait cycles
        instr = 32'h00209463;
        tick("bne_fetch_w1", 1'b0, 1'b0, 7'b1000000);
        tick("bne_fetch_w2", 1'b0, 1'b0, 7'b1000000);
        tick("bne_fetch",    1'b1, 1'b0, 7'b1100000);
        tick("bne_decode",   1'b0, 1'b0, 7'b0000000);
        tick("bne_exec",     1'b0, 1'b0, 7'b0000100);
        check("bne_ctrl", 32'(ctrl_vec()), 32'({4'd1, 3'd2, 2'd0, 5'b00110}));

        // ADDI x0,x0,1 after three wait cycles: counter must have restarted at FETCH entry
        instr = 32'h00100013;
        tick("addi_fetch_w1", 1'b0, 1'b0, 7'b1000000);
        tick("addi_fetch_w2", 1'b0, 1'b0, 7'b1000000);
        tick("addi_fetch_w3", 1'b0, 1'b0, 7'b1000000);
        tick("addi_fetch",    1'b1, 1'b0, 7'b1100000);
        tick("addi_decode",   1'b0, 1'b0, 7'b0000000);
        tick("addi_exec",     1'b0, 1'b0, 7'b0000000);
        check("addi_ctrl", 32'(ctrl_vec()), 32'({4'd0, 3'd0, 2'd1, 5'b10000}));
        tick("addi_wb",       1'b0, 1'b0, 7'b0000100);

        // illegal opcode 0x7F
        instr = 32'h0000007F;
        tick("ill_fetch",  1'b1, 1'b0, 7'b1100000);
        tick("ill_decode", 1'b0, 1'b0, 7'b0000000);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
        tick("ill_trap",   1'b0, 1'b0, 7'b0000001);
        tick("ill_halt",   1'b1, 1'b1, 7'b0000001);
`else
        tick("ill_exec",   1'b0, 1'b0, 7'b0000000);
        check("ill_ctrl", 32'(ctrl_vec()), 32'd0);
        tick("ill_wb",     1'b0, 1'b0, 7'b0000100);
`endif
        pulse_reset("rst_after_illegal");

        // fetch timeout, interrupted once by a reset pulse mid-FETCH
        instr = 32'h002081B3;
        tick("to_a_w1", 1'b0, 1'b0, 7'b1000000);
        tick("to_a_w2", 1'b0, 1'b0, 7'b1000000);
        pulse_reset("rst_mid_fetch");
        tick("to_b_w1", 1'b0, 1'b0, 7'b1000000);
        tick("to_b_w2", 1'b0, 1'b0, 7'b1000000);
        tick("to_b_w3", 1'b0, 1'b0, 7'b1000000);
        tick("to_b_w4", 1'b0, 1'b0, 7'b1000000);
        tick("to_fault", 1'b0, 1'b0, 7'b0000001);
        tick("to_halt",  1'b1, 1'b1, 7'b0000001);
        tick("to_halt2", 1'b0, 1'b0, 7'b0000001);
        pulse_reset("rst_clears_fault");
        tick("restart_fetch", 1'b1, 1'b0, 7'b1100000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
